// File: rtl/adbg_top_chain_ctrl.sv
// adbg_top_chain_ctrl
//   Top-level debug chain controller for the advanced debug interface.
//   Sits between the JTAG TAP and the debug sub-modules (bus, CPU, JSP, ...).
//   TDI is shifted into a shared data register that every module sees. A
//   command whose MSB is set is a module-select: its id field picks which
//   module slot owns the chain. That slot's TDO is then muxed onto tdo_o.
//
//   A select is rejected in two cases:
//     - any module reports inhibit (busy): the current selection is kept;
//     - the id points at an absent slot: no slot is selected and the sticky
//       select_err_o flag is set.
//
//   Optional feature, enabled by defining ADBG_TOP_STATUS_EN:
//     A 16-bit status word is loaded on Capture-DR and shifted out LSB-first
//     on tdo_o while no module is selected. Layout, MSB to LSB:
//       {NB_MODULES[5:0], inh_seen, select_err, req_id[3:0], 4'hA}
//     When the macro is undefined, tdo_o is 0 whenever no module is selected.
//
// Ports
//   tck_i            JTAG TCK, sole clock
//   tlr_i            Test-Logic-Reset, asynchronous, active high
//   tdi_i            JTAG TDI
//   tdo_o            JTAG TDO (combinational mux)
//   shift_dr_i       TAP in Shift-DR
//   pause_dr_i       TAP in Pause-DR (registers hold)
//   update_dr_i      TAP in Update-DR
//   capture_dr_i     TAP in Capture-DR (used only by the status register)
//   debug_select_i   DEBUG instruction active in IR
//   data_register_o  shift register contents, fanned out to all modules
//   module_select_o  one-hot (or all-zero) module select
//   module_tdo_i     per-module TDO
//   module_inhibit_i per-module "busy, do not reselect"
//   select_err_o     sticky flag: the last select targeted an absent slot
module adbg_top_chain_ctrl #(
  parameter int NB_MODULES       = 4,
  parameter int MODULE_ID_LENGTH = 2,
  parameter int DATAREG_LEN      = 64,
  parameter logic [NB_MODULES-1:0] MODULE_PRESENT = NB_MODULES'('hF)
) (
  input  logic                   tck_i,
  input  logic                   tlr_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  input  logic                   shift_dr_i,
  input  logic                   pause_dr_i,
  input  logic                   update_dr_i,
  input  logic                   capture_dr_i,
  input  logic                   debug_select_i,
  output logic [DATAREG_LEN-1:0] data_register_o,
  output logic [NB_MODULES-1:0]  module_select_o,
  input  logic [NB_MODULES-1:0]  module_tdo_i,
  input  logic [NB_MODULES-1:0]  module_inhibit_i,
  output logic                   select_err_o
);

  // Number of ids the id field can encode. Per-slot vectors are padded to
  // this width so that an out-of-range id indexes a 0 entry, not a
  // nonexistent one.
  localparam int ID_SLOTS = 2**MODULE_ID_LENGTH;

  logic [DATAREG_LEN-1:0]      sr_q, sr_d;
  logic [MODULE_ID_LENGTH-1:0] id_reg_q, id_reg_d;
  logic                        valid_q, valid_d;
  logic                        select_err_q, select_err_d;

  logic                        shift_en;
  logic                        select_evt;
  logic                        select_cmd;
  logic [MODULE_ID_LENGTH-1:0] id_in;
  logic                        inhibit_any;
  logic                        id_present;
  logic [ID_SLOTS-1:0]         present_ext;
  logic [ID_SLOTS-1:0]         tdo_ext;
  logic                        status_tdo;

  assign select_cmd  = sr_q[DATAREG_LEN-1];
  assign id_in       = sr_q[DATAREG_LEN-2 -: MODULE_ID_LENGTH];
  assign shift_en    = debug_select_i & shift_dr_i;
  assign select_evt  = debug_select_i & update_dr_i & select_cmd;
  assign inhibit_any = |module_inhibit_i;

  // Padded slot tables. An id >= NB_MODULES has a 0 present bit, so it
  // fails the same check as an unimplemented slot.
  for (genvar i = 0; i < ID_SLOTS; i++) begin : g_slot
    if (i < NB_MODULES) begin : g_impl
      assign present_ext[i]     = MODULE_PRESENT[i];
      assign tdo_ext[i]         = module_tdo_i[i];
      assign module_select_o[i] = valid_q & (id_reg_q == MODULE_ID_LENGTH'(i));
    end else begin : g_pad
      assign present_ext[i] = 1'b0;
      assign tdo_ext[i]     = 1'b0;
    end
  end

  assign id_present = present_ext[id_in];

  // Next-state logic for the shift register and the select state
  always_comb begin
    sr_d         = sr_q;
    id_reg_d     = id_reg_q;
    valid_d      = valid_q;
    select_err_d = select_err_q;

    if (shift_en) sr_d = {tdi_i, sr_q[DATAREG_LEN-1:1]};

    // Inhibit is checked first. A busy module keeps the current owner even
    // when the requested id would also be rejected as absent.
    if (select_evt && !inhibit_any) begin
      if (!id_present) begin
        valid_d      = 1'b0;
        select_err_d = 1'b1;
      end else begin
        id_reg_d     = id_in;
        valid_d      = 1'b1;
        select_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge tck_i or posedge tlr_i) begin
    if (tlr_i) begin
      sr_q         <= '0;
      id_reg_q     <= '0;
      valid_q      <= 1'b0;
      select_err_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      id_reg_q     <= id_reg_d;
      valid_q      <= valid_d;
      select_err_q <= select_err_d;
    end
  end

`ifdef ADBG_TOP_STATUS_EN
  localparam logic [5:0] NB_MODULES_6 = 6'(NB_MODULES);

  logic [15:0]                 st_q, st_d;
  logic [MODULE_ID_LENGTH-1:0] req_id_q, req_id_d;
  logic                        inh_seen_q, inh_seen_d;
  logic [3:0]                  req_id_4;

  // Fit the requested id into a 4-bit field: zero-extend or truncate.
  for (genvar k = 0; k < 4; k++) begin : g_req4
    if (k < MODULE_ID_LENGTH) begin : g_bit
      assign req_id_4[k] = req_id_q[k];
    end else begin : g_zero
      assign req_id_4[k] = 1'b0;
    end
  end

  always_comb begin
    st_d       = st_q;
    req_id_d   = req_id_q;
    inh_seen_d = inh_seen_q;

    // req_id records every select attempt, including rejected ones.
    // inh_seen is set by an inhibited attempt and cleared by a successful one.
    if (select_evt) begin
      req_id_d = id_in;
      if (inhibit_any)     inh_seen_d = 1'b1;
      else if (id_present) inh_seen_d = 1'b0;
    end

    // The status word owns the chain only while no module is selected.
    if (debug_select_i && !valid_q) begin
      if (capture_dr_i)
        st_d = {NB_MODULES_6, inh_seen_q, select_err_q, req_id_4, 4'hA};
      else if (shift_dr_i)
        st_d = {1'b0, st_q[15:1]};
    end
  end

  always_ff @(posedge tck_i or posedge tlr_i) begin
    if (tlr_i) begin
      st_q       <= '0;
      req_id_q   <= '0;
      inh_seen_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      req_id_q   <= req_id_d;
      inh_seen_q <= inh_seen_d;
    end
  end

  assign status_tdo = st_q[0];

  // Pause-DR only means "hold", and every register already holds by default.
  logic unused_inputs;
  assign unused_inputs = pause_dr_i;
`else
  assign status_tdo = 1'b0;

  // Without the status word, Capture-DR has no effect here. Pause-DR only
  // means "hold", which is already the default.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, capture_dr_i, pause_dr_i};
`endif

  assign tdo_o           = valid_q ? tdo_ext[id_reg_q] : status_tdo;
  assign data_register_o = sr_q;
  assign select_err_o    = select_err_q;

endmodule

// File: tb/tb_adbg_top_chain_ctrl.sv
module tb_adbg_top_chain_ctrl;
  logic        tck = 1'b0;
  logic        tlr = 1'b1;
  logic        tdi = 1'b0;
  logic        shift = 1'b0, pause = 1'b0, update = 1'b0, capture = 1'b0, dbg = 1'b0;
  logic [3:0]  mtdo = 4'h0, minh = 4'h0;
  logic        tdo;
  logic [63:0] dreg;
  logic [3:0]  msel;
  logic        serr;

  always #5 tck = ~tck;

  adbg_top_chain_ctrl #(
    .NB_MODULES(4), .MODULE_ID_LENGTH(2), .DATAREG_LEN(64), .MODULE_PRESENT(4'b0111)
  ) dut (
    .tck_i(tck), .tlr_i(tlr), .tdi_i(tdi), .tdo_o(tdo),
    .shift_dr_i(shift), .pause_dr_i(pause), .update_dr_i(update),
    .capture_dr_i(capture), .debug_select_i(dbg),
    .data_register_o(dreg), .module_select_o(msel), .module_tdo_i(mtdo),
    .module_inhibit_i(minh), .select_err_o(serr)
  );

  int n_run = 0, n_fail = 0;

  // Reference model: the slot that owns the chain (or none) and the error flag
  localparam int PRESENT = 'b0111;
  localparam int NSLOT   = 4;
  logic [63:0] sr_m = '0;
  bit          m_valid = 0;
  int          m_id = 0;
  bit          m_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_cmd(input bit cmd, input int id);
    logic [63:0] v;
    v = {$urandom, $urandom};
    v[63] = cmd;
    v[62:61] = 2'(id);
    return v;
  endfunction

  // Shift n bits of v, LSB first; the model register follows only when
  // DEBUG is active.
  task automatic shift_word(input logic [63:0] v, input int n, input bit d);
    @(negedge tck); dbg = d; shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = v[i];
      @(negedge tck);
      if (d) sr_m = {v[i], sr_m[63:1]};
    end
    shift = 1'b0;
  endtask

  // One Update-DR cycle, and the select rules applied to the model
  task automatic do_update(input logic [3:0] inh, input bit d);
    int id;
    @(negedge tck); dbg = d; minh = inh; update = 1'b1;
    @(negedge tck); update = 1'b0; minh = 4'h0; dbg = 1'b1;
    if (d && sr_m[63]) begin
      id = int'(sr_m[62:61]);
      if (inh != 4'h0) begin
        // busy module: keep the current owner and the error flag
      end else if (id >= NSLOT || ((PRESENT >> id) & 1) == 0) begin
        m_valid = 0; m_err = 1;
      end else begin
        m_valid = 1; m_id = id; m_err = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    mtdo = 4'($urandom);
    #1;
    chk({tag, " sel"},  64'(msel), m_valid ? 64'(1) << m_id : 64'(0));
    chk({tag, " err"},  64'(serr), 64'(m_err));
    chk({tag, " dreg"}, dreg, sr_m);
    if (m_valid) chk({tag, " tdo"}, 64'(tdo), 64'(mtdo[m_id]));
`ifndef ADBG_TOP_STATUS_EN
    else chk({tag, " tdo"}, 64'(tdo), 64'(0));
`endif
  endtask

  typedef struct {
    int         id;
    bit         cmd;
    logic [3:0] inh;
    logic [3:0] esel;
    bit         eerr;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v;
    logic [15:0] stw;

    vt[0] = '{2, 1, 4'b0000, 4'b0100, 0};  // select slot 2
    vt[1] = '{3, 1, 4'b0000, 4'b0000, 1};  // absent slot 3
    vt[2] = '{1, 1, 4'b0000, 4'b0010, 0};  // recovery clears the error
    vt[3] = '{0, 1, 4'b0010, 4'b0010, 0};  // inhibited: slot 1 kept
    vt[4] = '{3, 1, 4'b0001, 4'b0010, 0};  // inhibit beats absent
    vt[5] = '{0, 0, 4'b0000, 4'b0010, 0};  // module command, no select
    vt[6] = '{0, 1, 4'b0000, 4'b0001, 0};
    vt[7] = '{3, 1, 4'b0000, 4'b0000, 1};
    vt[8] = '{3, 1, 4'b1000, 4'b0000, 1};  // inhibit: error flag sticks
    vt[9] = '{2, 1, 4'b0000, 4'b0100, 0};

    // Reset state while tlr is held
    repeat (3) @(negedge tck);
    mtdo = 4'hF;
    #1;
    chk("reset sel", 64'(msel), 64'(0));
    chk("reset err", 64'(serr), 64'(0));
    chk("reset dreg", dreg, 64'(0));
    chk("reset tdo", 64'(tdo), 64'(0));
    @(negedge tck); tlr = 1'b0; dbg = 1'b1;

    // Table-driven selects
    for (int i = 0; i < 10; i++) begin
      v = mk_cmd(vt[i].cmd, vt[i].id);
      shift_word(v, 64, 1);
      do_update(vt[i].inh, 1);
      mtdo = 4'($urandom);
      #1;
      chk($sformatf("vec%0d sel", i), 64'(msel), 64'(vt[i].esel));
      chk($sformatf("vec%0d err", i), 64'(serr), 64'(vt[i].eerr));
      chk($sformatf("vec%0d dreg", i), dreg, v);
      if (vt[i].esel != 4'h0) chk($sformatf("vec%0d tdo", i), 64'(tdo), 64'(|(mtdo & vt[i].esel)));
`ifndef ADBG_TOP_STATUS_EN
      else chk($sformatf("vec%0d tdo", i), 64'(tdo), 64'(0));
`endif
    end

    // DEBUG not selected: no shift and no select
    shift_word(mk_cmd(1, 1), 64, 1);
    shift_word({$urandom, $urandom}, 64, 0);
    do_update(4'h0, 0);
    check_all("nodebug");
    do_update(4'h0, 1);
    check_all("debug again");

    // Pause-DR holds the register
    @(negedge tck); pause = 1'b1; tdi = 1'b1;
    repeat (5) @(negedge tck);
    pause = 1'b0;
    check_all("pause");

    // Random commands against the model
    for (int i = 0; i < 40; i++) begin
      shift_word(mk_cmd($urandom_range(0, 3) != 0, int'($urandom_range(0, 3))), 64, 1);
      do_update(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1);
      check_all($sformatf("rand%0d", i));
    end

    // Async reset in the middle of a shift, with the error flag set
    shift_word(mk_cmd(1, 3), 64, 1);
    do_update(4'h0, 1);
    check_all("pre-reset");
    @(negedge tck); shift = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tdi = 1'b1;
      @(negedge tck);
    end
    #2 tlr = 1'b1;
    sr_m = '0; m_valid = 0; m_err = 0;
    #1;
    chk("midshift reset dreg", dreg, 64'(0));
    chk("midshift reset sel", 64'(msel), 64'(0));
    chk("midshift reset err", 64'(serr), 64'(0));
    @(negedge tck); tlr = 1'b0; shift = 1'b0;

    // Rejected select right after reset, then read back the status word
    shift_word(mk_cmd(1, 3), 64, 1);
    do_update(4'h0, 1);
    check_all("absent after reset");
`ifdef ADBG_TOP_STATUS_EN
    @(negedge tck); capture = 1'b1;
    @(negedge tck); capture = 1'b0;
    tdi = 1'b0;
    for (int i = 0; i < 16; i++) begin
      shift = 1'b1;
      #1 stw[i] = tdo;
      @(negedge tck);
      sr_m = {1'b0, sr_m[63:1]};
    end
    shift = 1'b0;
    chk("status word", 64'(stw), 64'(16'h113A));
`endif
    shift_word(mk_cmd(1, 2), 64, 1);
    do_update(4'h0, 1);
    check_all("select after reset");
    chk("slot2 select", 64'(msel), 64'(4'b0100));

    // An inhibited reselect keeps slot 1 driving TDO through capture/shift
    shift_word(mk_cmd(1, 1), 64, 1);
    do_update(4'h0, 1);
    shift_word(mk_cmd(1, 0), 64, 1);
    do_update(4'b0010, 1);
    @(negedge tck); capture = 1'b1;
    @(negedge tck); capture = 1'b0;
    check_all("inhibit capture");
    shift_word({$urandom, $urandom}, 8, 1);
    check_all("inhibit shift");
    chk("inhibit keeps slot1", 64'(msel), 64'(4'b0010));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
